// File: rtl/matrix_tx_formatter.sv
// matrix_tx_formatter: prints a stored matrix (up to MAX_DIM x MAX_DIM,
// 8-bit unsigned elements) as decimal ASCII text for a UART TX stage.
// Elements in a row are separated by a single space and every row ends
// with CR LF. Elements are fetched row-major from synchronous storage.
module matrix_tx_formatter #(
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT, CONV, SEND_DIG, SEND_SP, SEND_CR, SEND_LF, FIN
  } state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIM);

  state_t     state_q, state_d;
  logic [2:0] rows_q, rows_d;
  logic [2:0] cols_q, cols_d;
  logic [2:0] r_q, r_d;
  logic [2:0] c_q, c_d;
  // Index of the digit being sent: 2 = hundreds, 1 = tens, 0 = ones.
  logic [1:0] didx_q, didx_d;

  logic [7:0] val_q;
  logic [3:0] hund_q, tens_q, ones_q;
  logic [3:0] cur_dig;
  logic       dims_ok;

  // Split an 8-bit value into {hundreds, tens, ones} decimal digits.
  function automatic logic [11:0] split_dec(input logic [7:0] v);
    logic [3:0] h, t, o;
    h = 4'(v / 8'd100);
    t = 4'((v % 8'd100) / 8'd10);
    o = 4'(v % 8'd10);
    return {h, t, o};
  endfunction

  // Index of the most significant non-zero digit (no leading zeros; 0 prints as "0").
  function automatic logic [1:0] first_digit(input logic [7:0] v);
    if (v >= 8'd100)     return 2'd2;
    else if (v >= 8'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  assign dims_ok = (rows != 3'd0) && ({1'b0, rows} <= MAXD) &&
                   (cols != 3'd0) && ({1'b0, cols} <= MAXD);

  // Control state: FSM state, latched dimensions and element counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q  <= 3'd0;
      cols_q  <= 3'd0;
      r_q     <= 3'd0;
      c_q     <= 3'd0;
      didx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
      didx_q  <= didx_d;
    end
  end

  // Element datapath: capture storage data in WAIT, split to digits in CONV.
  always_ff @(posedge clk) begin
    if (state_q == WAIT) val_q <= rd_data;
    if (state_q == CONV) {hund_q, tens_q, ones_q} <= split_dec(val_q);
  end

  // Next-state logic, counter updates and registered-state-derived outputs.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    r_d      = r_q;
    c_d      = c_q;
    didx_d   = didx_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    rd_addr  = ADDR_W'({5'd0, r_q} * {5'd0, cols_q} + {5'd0, c_q});

    case (didx_q)
      2'd2:    cur_dig = hund_q;
      2'd1:    cur_dig = tens_q;
      default: cur_dig = ones_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = rows;
          cols_d  = cols;
          r_d     = 3'd0;
          c_d     = 3'd0;
          state_d = dims_ok ? FETCH : FIN;
        end
      end
      FETCH: state_d = WAIT;
      WAIT:  state_d = CONV;
      CONV: begin
        didx_d  = first_digit(val_q);
        state_d = SEND_DIG;
      end
      SEND_DIG: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'd0, cur_dig};
        if (tx_ready) begin
          if (didx_q != 2'd0)             didx_d  = didx_q - 2'd1;
          else if (c_q == cols_q - 3'd1)  state_d = SEND_CR;
          else                            state_d = SEND_SP;
        end
      end
      SEND_SP: begin
        tx_valid = 1'b1;
        tx_data  = 8'h20;
        if (tx_ready) begin
          c_d     = c_q + 3'd1;
          state_d = FETCH;
        end
      end
      SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_d = SEND_LF;
      end
      SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          c_d = 3'd0;
          if (r_q == rows_q - 3'd1) begin
            state_d = FIN;
          end else begin
            r_d     = r_q + 3'd1;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Scoreboard bench for matrix_tx_formatter: expected bytes are queued when
// a print is started and popped as the DUT transfers bytes.
module tb_matrix_tx_formatter;

  localparam int MAX_DIM = 5;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        rows;
  logic [2:0]        cols;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  logic [7:0] mem [0:31];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  matrix_tx_formatter #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous storage model: one-cycle read latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on transfer, hold-stability, done pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", {31'd0, tx_valid}, 32'd1);
          check("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        end
        if (tx_valid && tx_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) check("extra_byte", {24'd0, tx_data}, 32'h100);
          else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        hold_pend = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (done) done_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  // Reference text model: decimal, no leading zeros, space-separated, CR LF rows.
  task automatic push_model(input int nr, input int nc);
    int v;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        v = int'(mem[r*nc+c]);
        if (v >= 100) exp_q.push_back(8'(48 + v/100));
        if (v >= 10)  exp_q.push_back(8'(48 + (v/10)%10));
        exp_q.push_back(8'(48 + v%10));
        if (c != nc-1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic do_start(input logic [2:0] r, input logic [2:0] c);
    rows  = r;
    cols  = c;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) cyc();
    check({tag, "_done"}, done_cnt, target);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    cyc();
    cyc();
    check({tag, "_one_done"}, done_cnt, target);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] seq22 [] = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h33, 8'h0D, 8'h0A};
  logic [7:0] seq23 [] = '{8'h30, 8'h20, 8'h31, 8'h30, 8'h0D, 8'h0A,
                           8'h32, 8'h35, 8'h35, 8'h20, 8'h37, 8'h0D, 8'h0A};

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; rows = 3'd0; cols = 3'd0; tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    cyc(); cyc(); cyc();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    cyc();

    // 1x3 [1,2,3], first-byte latency, inputs changed after acceptance
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
    push_bytes(seq22, 7);
    do_start(3'd1, 3'd3);
    rows = 3'd7; cols = 3'd0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("fetch_addr", {27'd0, rd_addr}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("latency_c%0d", k), {31'd0, tx_valid}, (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) cyc();
    end
    wait_done("r1c3", 1, 200);

    // 2x2 [0,10,255,7]
    mem[0] = 8'd0; mem[1] = 8'd10; mem[2] = 8'd255; mem[3] = 8'd7;
    push_bytes(seq23, 13);
    do_start(3'd2, 3'd2);
    wait_done("r2c2", 2, 300);

    // stall 20 cycles while the space byte is presented
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
    push_bytes(seq22, 7);
    do_start(3'd1, 3'd3);
    for (int i = 0; i < 50 && !(tx_valid && tx_data == 8'h20); i++) cyc();
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, tx_valid}, 32'd1);
      check("stall_data", {24'd0, tx_data}, 32'h20);
    end
    cyc();
    tx_ready = 1'b1;
    wait_done("stall", 3, 200);

    // start re-pulsed while busy is ignored
    push_bytes(seq22, 7);
    do_start(3'd1, 3'd3);
    cyc(); cyc(); cyc(); cyc();
    do_start(3'd2, 3'd2);
    wait_done("restart_ignored", 4, 200);

    // rows=0 and cols>MAX_DIM: immediate FIN, no bytes
    base = xfer_cnt;
    do_start(3'd0, 3'd3);
    check("rows0_done", {31'd0, done}, 32'd1);
    check("rows0_valid", {31'd0, tx_valid}, 32'd0);
    cyc();
    check("rows0_done_low", {31'd0, done}, 32'd0);
    check("rows0_busy_low", {31'd0, busy}, 32'd0);
    do_start(3'd2, 3'd6);
    check("cols6_done", {31'd0, done}, 32'd1);
    cyc();
    check("bad_dims_no_bytes", xfer_cnt - base, 0);
    check("bad_dims_done_cnt", done_cnt, 6);

    // reset after the 3rd byte abandons the print
    push_bytes(seq22, 7);
    base = xfer_cnt;
    do_start(3'd1, 3'd3);
    for (int i = 0; i < 100 && (xfer_cnt - base) < 3; i++) cyc();
    check("mid_reached_3", xfer_cnt - base, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) cyc();
    check("mid_rst_no_done", done_cnt, 6);
    push_bytes(seq22, 7);
    do_start(3'd1, 3'd3);
    wait_done("reprint", 7, 200);

    // 5x5 random data with random back-pressure
    for (int i = 0; i < 25; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd99; mem[3] = 8'd100; mem[24] = 8'd255;
    push_model(5, 5);
    do_start(3'd5, 3'd5);
    for (int i = 0; i < 3000 && done_cnt < 8; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    tx_ready = 1'b1;
    wait_done("r5c5_rand", 8, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
